// File: rtl/mge_reconfig_rmw_sequencer_if.sv
// Avalon-MM reconfig port between the RMW sequencer (master) and one transceiver channel (slave).
interface mge_reconfig_rmw_sequencer_if #(
    parameter int RCFG_AW = 11
);
    logic [RCFG_AW-1:0] rcfg_address;
    logic               rcfg_read;
    logic               rcfg_write;
    logic [31:0]        rcfg_writedata;
    logic [31:0]        rcfg_readdata;
    logic               rcfg_waitrequest;

    modport master (
        output rcfg_address, rcfg_read, rcfg_write, rcfg_writedata,
        input  rcfg_readdata, rcfg_waitrequest
    );

    modport slave (
        input  rcfg_address, rcfg_read, rcfg_write, rcfg_writedata,
        output rcfg_readdata, rcfg_waitrequest
    );
endinterface

// File: rtl/mge_reconfig_rmw_sequencer.sv
// Walks the per-rate reconfig table and applies each entry to one transceiver channel
// as a masked read-modify-write over its Avalon-MM reconfig port.
module mge_reconfig_rmw_sequencer #(
    parameter int ROM_DEPTH = 7,
    parameter int ROM_AW    = 3,
    parameter int RCFG_AW   = 11,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [25:0]          rom_data,
    mge_reconfig_rmw_sequencer_if.master rcfg
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_READ, S_WRITE, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [ROM_AW-1:0]  idx_q, idx_d;
    logic [RCFG_AW-1:0] addr_q, addr_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         val_q, val_d;
    logic [7:0]         wr_q, wr_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               tmo_hit;
    logic               unused_rd_hi;

    assign tmo_hit      = (tmo_q == TW'(TIMEOUT - 1));
    assign unused_rd_hi = ^rcfg.rcfg_readdata[31:8];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        val_d   = val_q;
        wr_d    = wr_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                addr_d  = RCFG_AW'(rom_data[25:16]);
                mask_d  = rom_data[15:8];
                val_d   = rom_data[7:0];
                tmo_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (rcfg.rcfg_waitrequest) begin
                    if (tmo_hit) state_d = S_ERR;
                    else         tmo_d   = tmo_q + 1'b1;
                end else begin
                    // merge straight from the bus so the write can issue next cycle
                    wr_d    = (rcfg.rcfg_readdata[7:0] & ~mask_q) | (val_q & mask_q);
                    tmo_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (rcfg.rcfg_waitrequest) begin
                    if (tmo_hit) state_d = S_ERR;
                    else         tmo_d   = tmo_q + 1'b1;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == ROM_AW'(ROM_DEPTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            val_q   <= '0;
            wr_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            val_q   <= val_d;
            wr_q    <= wr_d;
            tmo_q   <= tmo_d;
        end
    end

    // busy already drops in the done/error cycle; start is only honoured from IDLE
    assign busy                = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign done                = (state_q == S_DONE);
    assign error               = (state_q == S_ERR);
    assign rom_addr            = idx_q;
    assign rcfg.rcfg_address   = addr_q;
    assign rcfg.rcfg_read      = (state_q == S_READ);
    assign rcfg.rcfg_write     = (state_q == S_WRITE);
    assign rcfg.rcfg_writedata = {24'h0, wr_q};
endmodule

// File: tb/tb_mge_reconfig_rmw_sequencer.sv
// Directed bench: table walk against a stalling register-file slave, scoreboard of expected writes.
module tb_mge_reconfig_rmw_sequencer;
  localparam int RAW   = 11;
  localparam int CLKP  = 10;
  localparam int LIMIT = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [2:0]  rom_addr_a, rom_addr_b;
  logic [25:0] rom_data_a, rom_data_b;
  logic sel = 1'b0;
  logic wreq = 1'b0;
  logic [31:0] rdata = 32'h0;

  mge_reconfig_rmw_sequencer_if #(.RCFG_AW(RAW)) ifa ();
  mge_reconfig_rmw_sequencer_if #(.RCFG_AW(RAW)) ifb ();

  mge_reconfig_rmw_sequencer #(.ROM_DEPTH(7), .ROM_AW(3), .RCFG_AW(RAW), .TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .error(error_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rcfg(ifa)
  );
  mge_reconfig_rmw_sequencer #(.ROM_DEPTH(7), .ROM_AW(3), .RCFG_AW(RAW), .TIMEOUT(15)) dut_t (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .error(error_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rcfg(ifb)
  );

  always #(CLKP/2) clk = ~clk;

  // the slave model serves whichever instance sel points at
  assign ifa.rcfg_waitrequest = sel ? 1'b0 : wreq;
  assign ifb.rcfg_waitrequest = sel ? wreq : 1'b0;
  assign ifa.rcfg_readdata    = rdata;
  assign ifb.rcfg_readdata    = rdata;

  logic           s_rd, s_wr, busy_m, done_m, err_m;
  logic [RAW-1:0] s_addr;
  logic [31:0]    s_wd;
  assign s_rd   = sel ? ifb.rcfg_read      : ifa.rcfg_read;
  assign s_wr   = sel ? ifb.rcfg_write     : ifa.rcfg_write;
  assign s_addr = sel ? ifb.rcfg_address   : ifa.rcfg_address;
  assign s_wd   = sel ? ifb.rcfg_writedata : ifa.rcfg_writedata;
  assign busy_m = sel ? busy_b  : busy_a;
  assign done_m = sel ? done_b  : done_a;
  assign err_m  = sel ? error_b : error_a;

  logic [25:0] tbl [8];
  always @(posedge clk) begin
    rom_data_a <= tbl[rom_addr_a];
    rom_data_b <= tbl[rom_addr_b];
  end

  int n_cmp = 0, n_err = 0;
  logic [7:0] mem [2048];
  logic [7:0] img1 [2048];
  logic [RAW+7:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // slave model state
  int max_wait = 0, stall = 0, n_rd = 0, n_wr = 0, stuck_rd_n = 0;
  bit acc_on = 1'b0, stuck = 1'b0, hold_wr = 1'b0;
  logic [RAW-1:0] a_addr;
  logic a_rd, a_wr;
  logic [31:0] a_wd;
  logic [RAW+7:0] sb_exp;
  time stuck_t = 0;

  always @(negedge clk) begin
    if (s_rd || s_wr) begin
      chk("rd_wr_excl", 64'(s_rd & s_wr), 64'h0);
      if (!acc_on) begin
        acc_on = 1'b1;
        a_addr = s_addr; a_rd = s_rd; a_wr = s_wr; a_wd = s_wd;
        stall = (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
        if (s_rd) begin
          n_rd++;
          if (n_rd == stuck_rd_n) begin stuck = 1'b1; stuck_t = $time; end
        end
        if (s_wr && hold_wr) stuck = 1'b1;
      end else begin
        chk("bus_hold", 64'({s_addr, s_rd, s_wr, s_wd}), 64'({a_addr, a_rd, a_wr, a_wd}));
      end
      if (stuck || stall > 0) begin
        wreq  = 1'b1;
        rdata = $urandom;
        if (stall > 0) stall--;
      end else begin
        wreq   = 1'b0;
        acc_on = 1'b0;
        if (s_rd) begin
          rdata = {24'($urandom), mem[s_addr]};
        end else begin
          n_wr++;
          chk("wdata_hi_zero", 64'(s_wd[31:8]), 64'h0);
          chk("sb_nonempty", 64'(sb_q.size() != 0), 64'h1);
          if (sb_q.size() != 0) begin
            sb_exp = sb_q.pop_front();
            chk("sb_write", 64'({s_addr, s_wd[7:0]}), 64'(sb_exp));
          end
          mem[s_addr] = s_wd[7:0];
        end
      end
    end else begin
      acc_on = 1'b0;
      stuck  = 1'b0;
      wreq   = 1'b0;
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7);
    mem[11'h132] = 8'hFF;
    mem[11'h136] = 8'h53;
    mem[11'h13B] = 8'h00;
    mem[11'h140] = 8'h5C;
  endtask

  // expected write for every table entry against the current register image
  task automatic push_exp();
    logic [9:0] a;
    logic [7:0] m, v, e;
    for (int k = 0; k < 7; k++) begin
      a = tbl[k][25:16]; m = tbl[k][15:8]; v = tbl[k][7:0];
      e = (mem[a] & ~m) | (v & m);
      sb_q.push_back({RAW'(a), e});
    end
  endtask

  task automatic run_seq(input bit use_b, input bit poke, output int cyc,
                         output bit got_done, output bit got_err);
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    cyc = 1;
    chk("busy_rise", 64'(busy_m), 64'h1);
    while (!(done_m || err_m) && cyc < LIMIT) begin
      start_a = poke && (cyc % 7 == 3);
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    chk("run_bound", 64'(cyc < LIMIT), 64'h1);
    got_done = done_m;
    got_err  = err_m;
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_busy"},  64'(busy_a), 64'h0);
    chk({pfx, "_done"},  64'(done_a), 64'h0);
    chk({pfx, "_error"}, 64'(error_a), 64'h0);
    chk({pfx, "_read"},  64'(ifa.rcfg_read), 64'h0);
    chk({pfx, "_write"}, 64'(ifa.rcfg_write), 64'h0);
    chk({pfx, "_romaddr"}, 64'(rom_addr_a), 64'h0);
    chk({pfx, "_addr"},  64'(ifa.rcfg_address), 64'h0);
    chk({pfx, "_wdata"}, 64'(ifa.rcfg_writedata), 64'h0);
  endtask

  initial begin
    int  cyc, w0, diffs, k;
    bit  gd, ge;
    time te;
    tbl[0] = 26'h1320404;
    tbl[1] = {10'h136, 8'h0F, 8'h0A};
    tbl[2] = {10'h13B, 8'hFF, 8'h19};
    tbl[3] = {10'h140, 8'hF0, 8'hA0};
    tbl[4] = {10'h141, 8'h00, 8'h55};
    tbl[5] = {10'h000, 8'h81, 8'h80};
    tbl[6] = {10'h3FF, 8'h3C, 8'h24};
    tbl[7] = 26'h0;
    init_mem();

    // reset state
    repeat (3) @(negedge clk);
    chk_rst("rst");
    chk("rst_busy_t", 64'(busy_b), 64'h0);
    reset = 1'b0;

    // 1: zero-wait walk of the full table
    push_exp();
    w0 = n_wr;
    run_seq(1'b0, 1'b0, cyc, gd, ge);
    chk("s1_done", 64'(gd), 64'h1);
    chk("s1_err", 64'(ge), 64'h0);
    chk("s1_latency", 64'(cyc), 64'd36);
    chk("s1_busy_in_done", 64'(busy_a), 64'h0);
    chk("s1_nwr", 64'(n_wr - w0), 64'd7);
    chk("s1_sb_empty", 64'(sb_q.size()), 64'h0);
    chk("s1_r136", 64'(mem[11'h136]), 64'h5A);
    chk("s1_r13b", 64'(mem[11'h13B]), 64'h19);
    chk("s1_r132", 64'(mem[11'h132]), 64'hFF);
    chk("s1_r000", 64'(mem[11'h000]), 64'h80);
    chk("s1_r3ff", 64'(mem[11'h3FF]), 64'hE5);
    img1 = mem;

    // 2: masked single-bit entry with readback 0x00; other bits preserved
    @(negedge clk);
    mem[11'h132] = 8'h00;
    push_exp();
    run_seq(1'b0, 1'b0, cyc, gd, ge);
    chk("s2_done", 64'(gd), 64'h1);
    chk("s2_r132", 64'(mem[11'h132]), 64'h04);
    chk("s2_r140", 64'(mem[11'h140]), 64'hAC);
    chk("s2_r141", 64'(mem[11'h141]), 64'hC7);
    chk("s2_sb_empty", 64'(sb_q.size()), 64'h0);

    // 3: random 0-20 waitrequest on every access
    @(negedge clk);
    init_mem();
    max_wait = 20;
    push_exp();
    run_seq(1'b0, 1'b0, cyc, gd, ge);
    max_wait = 0;
    chk("s3_done", 64'(gd), 64'h1);
    chk("s3_err", 64'(ge), 64'h0);
    chk("s3_sb_empty", 64'(sb_q.size()), 64'h0);
    diffs = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== img1[i]) diffs++;
    chk("s3_image_diffs", 64'(diffs), 64'h0);

    // 4: third read stuck, TIMEOUT=15 instance
    @(negedge clk);
    sel = 1'b1;
    stuck_rd_n = n_rd + 3;
    w0 = n_wr;
    push_exp();
    run_seq(1'b1, 1'b0, cyc, gd, ge);
    te = $time;
    chk("s4_err", 64'(ge), 64'h1);
    chk("s4_done", 64'(gd), 64'h0);
    chk("s4_err_latency", 64'((te - stuck_t) / CLKP), 64'd15);
    chk("s4_busy", 64'(busy_b), 64'h0);
    chk("s4_nwr", 64'(n_wr - w0), 64'd2);
    chk("s4_sb_left", 64'(sb_q.size()), 64'd5);
    @(negedge clk);
    chk("s4_err_pulse", 64'(error_b), 64'h0);
    chk("s4_no_read", 64'(ifb.rcfg_read), 64'h0);
    sb_q.delete();
    stuck_rd_n = 0;
    sel = 1'b0;

    // 5: reset during a write stall, then replay from index 0
    @(negedge clk);
    hold_wr = 1'b1;
    push_exp();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (!ifa.rcfg_write && k < 50) begin @(negedge clk); k++; end
    chk("s5_wr_bound", 64'(k < 50), 64'h1);
    repeat (3) @(negedge clk);
    chk("s5_wr_stalled", 64'(ifa.rcfg_write), 64'h1);
    reset = 1'b1;
    hold_wr = 1'b0;
    @(negedge clk);
    chk_rst("s5_rst");
    reset = 1'b0;
    sb_q.delete();
    push_exp();
    w0 = n_wr;
    run_seq(1'b0, 1'b0, cyc, gd, ge);
    chk("s5_done", 64'(gd), 64'h1);
    chk("s5_nwr", 64'(n_wr - w0), 64'd7);
    chk("s5_sb_empty", 64'(sb_q.size()), 64'h0);

    // 6: start while busy and in the done cycle is ignored
    push_exp();
    w0 = n_wr;
    run_seq(1'b0, 1'b1, cyc, gd, ge);
    chk("s6_done", 64'(gd), 64'h1);
    chk("s6_latency", 64'(cyc), 64'd36);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("s6_start_in_done", 64'(busy_a), 64'h0);
    repeat (3) @(negedge clk);
    chk("s6_idle", 64'(busy_a), 64'h0);
    chk("s6_nwr", 64'(n_wr - w0), 64'd7);
    chk("s6_sb_empty", 64'(sb_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
